apb_slave_regmem: RTL and testbench

- Parametrised APB4 completer: word-addressed register memory with byte strobes, configurable wait states, a read-only upper region, and PSLVERR error detection.
- Next-generation DUT for the APB slave UVM environment; replaces the fixed-width single-bit slave model.
- Sits directly behind the bench interface's driver/monitor signals.

---
 rtl/apb_slave_regmem_if.sv | 25 ++
 rtl/apb_slave_regmem.sv | 120 ++++++++++++
 tb/tb_apb_slave_regmem.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_slave_regmem_if.sv
// rtl/apb_slave_regmem_if.sv - APB4 bus bundle between requester and register-memory completer
interface apb_slave_regmem_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regmem.sv
// rtl/apb_slave_regmem.sv - APB4 completer: byte-strobed word memory, wait states, RO region, PSLVERR
module apb_slave_regmem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0,
  parameter int RO_START    = MEM_DEPTH
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  apb_slave_regmem_if.slave     apb,
  output logic [7:0]            err_cnt_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   RO_L     = (ADDR_WIDTH + 1)'(RO_START);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam logic [3:0]            WAIT_L   = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic                  err_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [7:0]            err_cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH:0]   idx_full_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] rd_setup_d;
  logic [DATA_WIDTH-1:0] rd_access_d;

  // Extra top bit keeps out-of-range indices distinguishable from wrapped ones.
  assign idx_full_d = {1'b0, apb.paddr >> OFF_W};
  assign idx_d      = idx_full_d[IDX_W-1:0];
  assign err_d      = (|(apb.paddr & OFF_MASK)) || (idx_full_d >= DEPTH_L) ||
                      (apb.pwrite && (idx_full_d >= RO_L));

  assign rd_setup_d  = (err_d || apb.pwrite) ? '0 : mem_q[idx_d];
  assign rd_access_d = (err_q || write_q)     ? '0 : mem_q[idx_q];

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      err_cnt_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (apb.psel && !apb.penable) begin
            idx_q   <= idx_d;
            write_q <= apb.pwrite;
            err_q   <= err_d;
            cnt_q   <= WAIT_L;
            state_q <= S_ACCESS;
            // Zero wait states: the first access cycle is already the completion cycle.
            if (WAIT_STATES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rd_setup_d;
            end
          end
        end
        S_ACCESS: begin
          if (!pready_q) begin
            if (!apb.psel) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                pready_q  <= 1'b1;
                pslverr_q <= err_q;
                prdata_q  <= rd_access_d;
              end
            end
          end else begin
            // Write data and strobes are taken on the completion edge, not at setup.
            if (write_q && !err_q) begin
              for (int k = 0; k < STRB_W; k++) begin
                if (apb.pstrb[k]) begin
                  mem_q[idx_q][8*k +: 8] <= apb.pwdata[8*k +: 8];
                end
              end
            end
            if (err_q && (err_cnt_q != 8'hFF)) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign err_cnt_o   = err_cnt_q;
endmodule

// File: tb/tb_apb_slave_regmem.sv
// tb/tb_apb_slave_regmem.sv - randomized model-checked bench for apb_slave_regmem (0 and 3 wait states)
module tb_apb_slave_regmem;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int RO    = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          sel;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [7:0]    err_cnt0, err_cnt3;

  apb_slave_regmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_slave_regmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  assign bus0.psel    = psel & ~sel;
  assign bus0.penable = penable & ~sel;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;
  assign bus3.psel    = psel & sel;
  assign bus3.penable = penable & sel;
  assign bus3.pwrite  = pwrite;
  assign bus3.paddr   = paddr;
  assign bus3.pwdata  = pwdata;
  assign bus3.pstrb   = pstrb;

  apb_slave_regmem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                     .WAIT_STATES(0), .RO_START(RO)) u_dut0 (
    .pclk_i(clk), .preset_i(rst), .apb(bus0), .err_cnt_o(err_cnt0));
  apb_slave_regmem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                     .WAIT_STATES(3), .RO_START(RO)) u_dut3 (
    .pclk_i(clk), .preset_i(rst), .apb(bus3), .err_cnt_o(err_cnt3));

  logic        pready_a, pslverr_a;
  logic [31:0] prdata_a;
  assign pready_a  = sel ? bus3.pready  : bus0.pready;
  assign pslverr_a = sel ? bus3.pslverr : bus0.pslverr;
  assign prdata_a  = sel ? bus3.prdata  : bus0.prdata;

  logic [31:0] mdl_mem [2][DEPTH];
  int          mdl_errs [2];
  logic        exp_pready, exp_pslverr;
  logic [31:0] exp_prdata;
  logic        chk_en = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_done = 0;
  int          prev_done = 0;
  logic [31:0] last_rd = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pready",   32'(pready_a),  32'(exp_pready));
      chk("pslverr",  32'(pslverr_a), 32'(exp_pslverr));
      chk("prdata",   prdata_a,       exp_prdata);
      chk("err_cnt0", 32'(err_cnt0),  32'(mdl_errs[0]));
      chk("err_cnt3", 32'(err_cnt3),  32'(mdl_errs[1]));
      if (pready_a === 1'b1) begin
        last_rd   = prdata_a;
        last_err  = pslverr_a;
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  task automatic exp_idle();
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_prdata  = '0;
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      mdl_errs[d] = 0;
      for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = '0;
    end
  endtask

  // One full transfer on the selected DUT; abort_at>0 drops PSEL in that access cycle.
  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int abort_at);
    int ws, idx;
    bit err, done;
    ws  = sel ? 3 : 0;
    idx = int'(a >> 2);
    err = (a[1:0] != 2'b00) || (idx >= DEPTH) || (w && (idx >= RO));
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a;
    pwdata = $urandom; pstrb = 4'($urandom);
    exp_idle();
    @(posedge clk); #1;
    penable = 1'b1;
    for (int j = 1; j <= ws + 1; j++) begin
      if (j == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        exp_idle();
        @(posedge clk); #1;
        return;
      end
      done        = (j == ws + 1);
      pwdata      = done ? d : $urandom;
      pstrb       = done ? s : 4'($urandom);
      exp_pready  = done;
      exp_pslverr = done && err;
      exp_prdata  = (done && !err && !w) ? mdl_mem[sel][idx] : 32'h0;
      @(posedge clk); #1;
    end
    if (w && !err)
      for (int k = 0; k < 4; k++)
        if (s[k]) mdl_mem[sel][idx][8*k +: 8] = d[8*k +: 8];
    if (err && mdl_errs[sel] < 255) mdl_errs[sel]++;
    psel = 1'b0; penable = 1'b0;
    exp_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, ridx, cyc_before;
    logic [AW-1:0] ra;
    sel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    exp_idle();
    mdl_reset();
    rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_err_cnt0", 32'(err_cnt0), 32'h0);

    xfer(1, 10'h004, 32'hDEADBEEF, 4'hF, 0);
    xfer(0, 10'h004, 32'h0, 4'h0, 0);
    chk("rd_0x04", last_rd, 32'hDEADBEEF);
    chk("rd_0x04_err", 32'(last_err), 32'h0);

    xfer(1, 10'h004, 32'h11223344, 4'h5, 0);
    xfer(0, 10'h004, 32'h0, 4'hF, 0);
    chk("strobe_0x5", last_rd, 32'hDE22BE44);

    xfer(0, 10'h100, 32'h0, 4'h0, 0);
    chk("oor_rd_data", last_rd, 32'h0);
    chk("oor_rd_err", 32'(last_err), 32'h1);
    xfer(1, 10'h002, 32'h55555555, 4'hF, 0);
    chk("misalign_err", 32'(last_err), 32'h1);
    xfer(1, 10'h0F0, 32'h77777777, 4'hF, 0);
    chk("ro_wr_err", 32'(last_err), 32'h1);
    xfer(0, 10'h0F0, 32'h0, 4'h0, 0);
    chk("ro_rd_data", last_rd, 32'h0);
    chk("ro_rd_err", 32'(last_err), 32'h0);
    chk("err_cnt_3", 32'(err_cnt0), 32'h3);

    sel = 1'b1;
    xfer(1, 10'h000, 32'hA5A55A5A, 4'hF, 0);
    xfer(0, 10'h000, 32'h0, 4'h0, 0);
    xfer(0, 10'h000, 32'h0, 4'h0, 0);
    chk("b2b_gap", 32'(last_done - prev_done), 32'd5);
    chk("ws3_rd", last_rd, 32'hA5A55A5A);

    xfer(0, 10'h100, 32'h0, 4'h0, 0);
    xfer(1, 10'h00C, 32'h12345678, 4'hF, 2);
    chk("abort_err_cnt", 32'(err_cnt3), 32'h1);
    xfer(0, 10'h00C, 32'h0, 4'h0, 0);
    chk("abort_no_write", last_rd, 32'h0);
    xfer(1, 10'h00C, 32'h12345678, 4'hF, 0);
    xfer(0, 10'h00C, 32'h0, 4'h0, 0);
    chk("after_abort_rd", last_rd, 32'h12345678);

    repeat (300) begin
      sel = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        psel = 1'b1; penable = 1'b1;
        exp_idle();
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
      end
      mode = $urandom_range(0, 5);
      ridx = $urandom_range(0, DEPTH - 1);
      case (mode)
        3:       ra = AW'(4 * $urandom_range(RO, DEPTH - 1));
        4:       ra = AW'(4 * ridx + $urandom_range(1, 3));
        5:       ra = AW'(4 * $urandom_range(DEPTH, 255));
        default: ra = AW'(4 * ridx);
      endcase
      xfer(1'($urandom), ra, $urandom, 4'($urandom),
           (sel && $urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end

    sel = 1'b0;
    repeat (260) xfer(0, 10'h100, 32'h0, 4'h0, 0);
    chk("err_cnt_sat", 32'(err_cnt0), 32'd255);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h008;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    exp_idle();
    @(posedge clk); #1;
    penable = 1'b1;
    exp_pready = 1'b1;
    #1 rst = 1'b1;
    exp_idle();
    mdl_reset();
    #1;
    chk("async_rst_pready", 32'(pready_a), 32'h0);
    chk("async_rst_err_cnt", 32'(err_cnt0), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    cyc_before = cyc;
    xfer(0, 10'h008, 32'h0, 4'h0, 0);
    chk("rst_mem2", last_rd, 32'h0);
    chk("post_rst_accept", 32'(last_done > cyc_before), 32'h1);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
